// File: rtl/ct_had_dbgreq_ctrl.sv
// HAD debug-entry control: merges debug-request sources, runs the enter/exit
// handshake with the RTU, records the entry cause and gates trace enable.
module ct_had_dbgreq_ctrl #(
    parameter int TMO_W = 8
) (
    input  logic       cpuclk,
    input  logic       cpurst_b,
    input  logic       trace_ctrl_req,
    input  logic       inst_bkpt_dbgreq,
    input  logic       mbkpt_ctrl_req,
    input  logic       regs_ctrl_halt_req,
    input  logic       regs_ctrl_exit_req,
    input  logic       regs_ctrl_tme,
    input  logic       pad_had_ext_dbgreq,
    input  logic       rtu_yy_xx_dbgon,
    output logic       ctrl_trace_en,
    output logic       ctrl_rtu_dbg_req,
    output logic       ctrl_rtu_exit_req,
    output logic [2:0] ctrl_regs_dbg_cause,
    output logic       ctrl_regs_dbg_ack,
    output logic       ctrl_regs_req_tmo
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        DEBUG = 2'b10,
        EXIT  = 2'b11
    } state_t;

    localparam logic [TMO_W-1:0] TMO_MAX  = '1;
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t           cur_state;
    state_t           nxt_state;
    logic             halt_pend;
    logic [TMO_W-1:0] tmo_cnt;
    logic             req_tmo;
    logic [2:0]       dbg_cause;
    logic [2:0]       nxt_cause;
    logic             dbg_ack;
    logic             any_src;
    logic             req_entry;
    logic             dbg_entry;

    // Highest-priority active source; 000 means nothing is requesting.
    always_comb begin
        nxt_cause = 3'b000;
        if (inst_bkpt_dbgreq) begin
            nxt_cause = 3'b010;
        end else if (mbkpt_ctrl_req) begin
            nxt_cause = 3'b011;
        end else if (trace_ctrl_req) begin
            nxt_cause = 3'b100;
        end else if (halt_pend) begin
            nxt_cause = 3'b001;
        end else if (pad_had_ext_dbgreq) begin
            nxt_cause = 3'b101;
        end
    end

    assign any_src   = (nxt_cause != 3'b000);
    assign req_entry = (cur_state == IDLE) && any_src;
    assign dbg_entry = (cur_state == REQ) && rtu_yy_xx_dbgon;

    always_comb begin
        nxt_state = cur_state;
        unique case (cur_state)
            IDLE:    if (any_src)             nxt_state = REQ;
            REQ:     if (rtu_yy_xx_dbgon)     nxt_state = DEBUG;
            DEBUG:   if (regs_ctrl_exit_req)  nxt_state = EXIT;
            EXIT:    if (!rtu_yy_xx_dbgon)    nxt_state = IDLE;
            default:                          nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // A halt in DEBUG only counts when it arrives with the resume command.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            halt_pend <= 1'b0;
        end else if (regs_ctrl_halt_req && ((cur_state != DEBUG) || regs_ctrl_exit_req)) begin
            halt_pend <= 1'b1;
        end else if (dbg_entry) begin
            halt_pend <= 1'b0;
        end
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            tmo_cnt <= '0;
            req_tmo <= 1'b0;
        end else if (req_entry) begin
            tmo_cnt <= '0;
            req_tmo <= 1'b0;
        end else if (cur_state == REQ) begin
            if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_cnt == TMO_LAST) begin
                req_tmo <= 1'b1;
            end
        end
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            dbg_cause <= 3'b000;
            dbg_ack   <= 1'b0;
        end else begin
            dbg_ack <= dbg_entry;
            if (req_entry) begin
                dbg_cause <= nxt_cause;
            end
        end
    end

    // Qualified by reset so every output reads 0 while reset is held.
    assign ctrl_trace_en       = regs_ctrl_tme && (cur_state == IDLE) && cpurst_b;
    assign ctrl_rtu_dbg_req    = (cur_state == REQ);
    assign ctrl_rtu_exit_req   = (cur_state == EXIT);
    assign ctrl_regs_dbg_cause = dbg_cause;
    assign ctrl_regs_dbg_ack   = dbg_ack;
    assign ctrl_regs_req_tmo   = req_tmo;

endmodule

// File: tb/tb_ct_had_dbgreq_ctrl.sv
// Scoreboard bench for ct_had_dbgreq_ctrl: directed vectors push hand-computed
// expectations, a monitor pops and compares them after each clock edge.
module tb_ct_had_dbgreq_ctrl;

    // Stimulus masks: {rst_n, tme, trace, ibkpt, mbkpt, halt, exit, ext, dbgon}
    localparam logic [8:0] I_RUN   = 9'h100;
    localparam logic [8:0] I_TME   = 9'h080;
    localparam logic [8:0] I_TR    = 9'h040;
    localparam logic [8:0] I_IB    = 9'h020;
    localparam logic [8:0] I_MB    = 9'h010;
    localparam logic [8:0] I_HALT  = 9'h008;
    localparam logic [8:0] I_EXIT  = 9'h004;
    localparam logic [8:0] I_EXT   = 9'h002;
    localparam logic [8:0] I_DBGON = 9'h001;

    // Expected masks: {trace_en, dbg_req, exit_req, cause[2:0], ack, tmo}
    localparam logic [7:0] E_NONE = 8'h00;
    localparam logic [7:0] E_TE   = 8'h80;
    localparam logic [7:0] E_REQ  = 8'h40;
    localparam logic [7:0] E_EXR  = 8'h20;
    localparam logic [7:0] E_ACK  = 8'h02;
    localparam logic [7:0] E_TMO  = 8'h01;

    typedef struct {
        string      name;
        logic [7:0] expv;
    } exp_t;

    logic       cpuclk = 1'b0;
    logic       cpurst_b = 1'b0;
    logic       trace_ctrl_req = 1'b0;
    logic       inst_bkpt_dbgreq = 1'b0;
    logic       mbkpt_ctrl_req = 1'b0;
    logic       regs_ctrl_halt_req = 1'b0;
    logic       regs_ctrl_exit_req = 1'b0;
    logic       regs_ctrl_tme = 1'b0;
    logic       pad_had_ext_dbgreq = 1'b0;
    logic       rtu_yy_xx_dbgon = 1'b0;
    logic       ctrl_trace_en;
    logic       ctrl_rtu_dbg_req;
    logic       ctrl_rtu_exit_req;
    logic [2:0] ctrl_regs_dbg_cause;
    logic       ctrl_regs_dbg_ack;
    logic       ctrl_regs_req_tmo;
    logic [7:0] obs_vec;

    exp_t sb_queue[$];
    event sample_now;
    int   checks = 0;
    int   errors = 0;

    ct_had_dbgreq_ctrl #(.TMO_W(3)) dut (
        .cpuclk              (cpuclk),
        .cpurst_b            (cpurst_b),
        .trace_ctrl_req      (trace_ctrl_req),
        .inst_bkpt_dbgreq    (inst_bkpt_dbgreq),
        .mbkpt_ctrl_req      (mbkpt_ctrl_req),
        .regs_ctrl_halt_req  (regs_ctrl_halt_req),
        .regs_ctrl_exit_req  (regs_ctrl_exit_req),
        .regs_ctrl_tme       (regs_ctrl_tme),
        .pad_had_ext_dbgreq  (pad_had_ext_dbgreq),
        .rtu_yy_xx_dbgon     (rtu_yy_xx_dbgon),
        .ctrl_trace_en       (ctrl_trace_en),
        .ctrl_rtu_dbg_req    (ctrl_rtu_dbg_req),
        .ctrl_rtu_exit_req   (ctrl_rtu_exit_req),
        .ctrl_regs_dbg_cause (ctrl_regs_dbg_cause),
        .ctrl_regs_dbg_ack   (ctrl_regs_dbg_ack),
        .ctrl_regs_req_tmo   (ctrl_regs_req_tmo)
    );

    assign obs_vec = {ctrl_trace_en, ctrl_rtu_dbg_req, ctrl_rtu_exit_req,
                      ctrl_regs_dbg_cause, ctrl_regs_dbg_ack, ctrl_regs_req_tmo};

    always #5 cpuclk = ~cpuclk;

    function automatic logic [7:0] cz(input logic [2:0] c);
        return {3'b000, c, 2'b00};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] expv);
        checks++;
        if (obs_vec !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got te/req/exr/cause/ack/tmo=%b required %b at %0t",
                     name, obs_vec, expv, $time);
        end
    endtask

    // Drive one vector at the falling edge; the expectation is for the outputs
    // after the next rising edge, or immediately when 'now' is set.
    task automatic applyStimulus(input string name, input logic [8:0] stim,
                                 input logic [7:0] expv, input bit now = 1'b0);
        exp_t e;
        @(negedge cpuclk);
        cpurst_b           = stim[8];
        regs_ctrl_tme      = stim[7];
        trace_ctrl_req     = stim[6];
        inst_bkpt_dbgreq   = stim[5];
        mbkpt_ctrl_req     = stim[4];
        regs_ctrl_halt_req = stim[3];
        regs_ctrl_exit_req = stim[2];
        pad_had_ext_dbgreq = stim[1];
        rtu_yy_xx_dbgon    = stim[0];
        e.name = name;
        e.expv = expv;
        sb_queue.push_back(e);
        if (now) begin
            -> sample_now;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge cpuclk or sample_now);
            #1;
            if (sb_queue.size() > 0) begin
                e = sb_queue.pop_front();
                checkOutput(e.name, e.expv);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach the end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        // Reset state, then trace expiry with tme set
        applyStimulus("rst_hold",      I_TME,                 E_NONE, 1'b1);
        applyStimulus("idle_te",       I_RUN | I_TME,         E_TE);
        applyStimulus("t1_req",        I_RUN | I_TME | I_TR,  E_REQ | cz(3'b100));
        applyStimulus("t1_req_hold1",  I_RUN | I_TME,         E_REQ | cz(3'b100));
        applyStimulus("t1_req_hold2",  I_RUN | I_TME,         E_REQ | cz(3'b100));
        applyStimulus("t1_ack",        I_RUN | I_TME | I_DBGON, E_ACK | cz(3'b100));
        applyStimulus("t1_ack_once",   I_RUN | I_TME | I_DBGON, cz(3'b100));
        applyStimulus("t1_exit",       I_RUN | I_TME | I_EXIT | I_DBGON, E_EXR | cz(3'b100));
        applyStimulus("t1_idle",       I_RUN | I_TME,         E_TE | cz(3'b100));

        // Priority: inst bkpt wins; cause frozen during REQ
        applyStimulus("t2_prio",       I_RUN | I_TME | I_IB | I_MB | I_TR, E_REQ | cz(3'b010));
        applyStimulus("t2_frozen",     I_RUN | I_TME | I_MB,  E_REQ | cz(3'b010));
        applyStimulus("t2_ack",        I_RUN | I_TME | I_DBGON, E_ACK | cz(3'b010));

        // Halt with exit in DEBUG re-enters after one IDLE cycle
        applyStimulus("t3_exit",       I_RUN | I_TME | I_HALT | I_EXIT | I_DBGON, E_EXR | cz(3'b010));
        applyStimulus("t3_idle1",      I_RUN | I_TME,         E_TE | cz(3'b010));
        applyStimulus("t3_reenter",    I_RUN | I_TME,         E_REQ | cz(3'b001));
        applyStimulus("t3_ack",        I_RUN | I_TME | I_DBGON, E_ACK | cz(3'b001));

        // Halt alone in DEBUG is discarded
        applyStimulus("t4_halt_drop",  I_RUN | I_TME | I_HALT | I_DBGON, cz(3'b001));
        applyStimulus("t4_exit",       I_RUN | I_TME | I_EXIT | I_DBGON, E_EXR | cz(3'b001));
        applyStimulus("t4_idle1",      I_RUN | I_TME,         E_TE | cz(3'b001));
        applyStimulus("t4_idle2",      I_RUN | I_TME,         E_TE | cz(3'b001));
        applyStimulus("t4_tme_off",    I_RUN,                 cz(3'b001));

        // Request timeout with TMO_W=3
        applyStimulus("t5_ext_req",    I_RUN | I_EXT,         E_REQ | cz(3'b101));
        for (int k = 1; k <= 6; k++) begin
            applyStimulus($sformatf("t5_wait%0d", k), I_RUN, E_REQ | cz(3'b101));
        end
        applyStimulus("t5_tmo_set",    I_RUN,                 E_REQ | E_TMO | cz(3'b101));
        applyStimulus("t5_tmo_sat",    I_RUN,                 E_REQ | E_TMO | cz(3'b101));
        applyStimulus("t5_ack",        I_RUN | I_DBGON,       E_ACK | E_TMO | cz(3'b101));
        applyStimulus("t5_exit",       I_RUN | I_EXIT | I_DBGON, E_EXR | E_TMO | cz(3'b101));
        applyStimulus("t5_idle",       I_RUN,                 E_TMO | cz(3'b101));
        applyStimulus("t5_tmo_clr",    I_RUN | I_IB,          E_REQ | cz(3'b010));

        // Reset while in EXIT clears everything immediately
        applyStimulus("t6_debug",      I_RUN | I_DBGON,       E_ACK | cz(3'b010));
        applyStimulus("t6_exit",       I_RUN | I_EXIT | I_DBGON, E_EXR | cz(3'b010));
        applyStimulus("t6_rst_now",    I_TME | I_DBGON,       E_NONE, 1'b1);
        applyStimulus("t6_rst_edge",   I_TME | I_DBGON | I_TR, E_NONE);
        applyStimulus("t6_release",    I_RUN | I_TME,         E_TE);

        // Halt issued in IDLE goes through halt_pend
        applyStimulus("halt_idle",     I_RUN | I_TME | I_HALT, E_TE);
        applyStimulus("halt_req",      I_RUN | I_TME,         E_REQ | cz(3'b001));
        applyStimulus("halt_ack",      I_RUN | I_TME | I_DBGON, E_ACK | cz(3'b001));

        repeat (3) @(posedge cpuclk);
        #2;
        checks++;
        if (sb_queue.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: got %0d pending required 0", sb_queue.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
